// File: rtl/pwm_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_capture_if
//  Description : Result handshake between pwm_capture (producer) and its
//                consumer: measured width, level valid and acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_capture_if;
  logic [31:0] pulse_length;
  logic        new_data_ready;
  logic        data_recieved;

  // Producer side: the capture block
  modport master (
    output pulse_length,
    output new_data_ready,
    input  data_recieved
  );

  // Consumer side: control logic reading results
  modport slave (
    input  pulse_length,
    input  new_data_ready,
    output data_recieved
  );
endinterface
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_capture
//  Description : Measures the high time of a servo-style PWM input in clk
//                cycles, range-checks it, presents valid widths on a level
//                handshake and flags loss of signal.
//                Optional macro PWM_GLITCH_FILTER_EN inserts a debouncer of
//                FILTER_DEPTH cycles after the synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture #(
  parameter logic [31:0] MIN_PULSE_LENGTH = 32'hD0FC,
  parameter logic [31:0] MAX_PULSE_LENGTH = 32'h17CDC,
  parameter logic [31:0] TIMEOUT          = 32'h2191C0,
  parameter int unsigned FILTER_DEPTH     = 4
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  input  wire logic         pwm_in,
  pwm_capture_if.master     bus,
  output logic              range_err,
  output logic              overrun,
  output logic              signal_lost
);

  typedef enum logic [1:0] {
    SYNC      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2
  } state_t;

  // Cycles after reset before the level pipeline reflects pwm_in; the
  // filter allowance is included so both builds share one settle rule.
  localparam int unsigned WARM   = 3 + FILTER_DEPTH;
  localparam int unsigned WARM_W = $clog2(WARM + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM);

  logic        s1, s2, s3;
  logic        level;
  logic        rise_q, fall_q;
  logic [31:0] high_cnt;
  logic [31:0] since_rise;
  logic [WARM_W-1:0] warm_cnt;
  state_t      state, state_nxt;

  logic timeout_hit;
  logic warm_done;
  logic eval;
  logic in_range;
  logic good;
  logic bad;

  // Two-flop synchronizer for the asynchronous line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  localparam int unsigned FW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_DEPTH - 1);

  logic          filt;
  logic [FW-1:0] filt_cnt;

  // Debouncer: follow s2 only after it has disagreed for FILTER_DEPTH cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt     <= 1'b0;
      filt_cnt <= '0;
    end else if (s2 != filt) begin
      if (filt_cnt == FILT_LAST) begin
        filt     <= s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  assign level = filt;
`else
  assign level = s2;
`endif

  // Previous level and registered edges; rise_q/fall_q line up with s3
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3     <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s3     <= level;
      rise_q <= level & ~s3;
      fall_q <= ~level & s3;
    end
  end

  // Settle counter so a pulse in progress at reset is never mistaken for a rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      warm_cnt <= '0;
    else if (warm_cnt != WARM_LAST)
      warm_cnt <= warm_cnt + 1'b1;
  end

  // Saturating cycles-since-last-rise counter for loss-of-signal detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      since_rise <= '0;
    else if (rise_q)
      since_rise <= '0;
    else if (since_rise != 32'hFFFF_FFFF)
      since_rise <= since_rise + 32'd1;
  end

  assign warm_done   = (warm_cnt == WARM_LAST);
  assign timeout_hit = (since_rise == TIMEOUT);
  assign eval        = (state == HIGH) && fall_q && !timeout_hit;
  assign in_range    = (high_cnt >= MIN_PULSE_LENGTH) && (high_cnt <= MAX_PULSE_LENGTH);
  assign good        = eval && in_range;
  assign bad         = eval && !in_range;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= SYNC;
    else
      state <= state_nxt;
  end

  // Next-state logic; a timeout abandons any measurement in progress
  always_comb begin
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = SYNC;
    end else begin
      case (state)
        SYNC:      if (warm_done && !s3) state_nxt = WAIT_RISE;
        WAIT_RISE: if (rise_q)           state_nxt = HIGH;
        HIGH:      if (fall_q)           state_nxt = WAIT_RISE;
        default:                         state_nxt = SYNC;
      endcase
    end
  end

  // High-time counter: starts at 1 on the rise, saturates instead of wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      high_cnt <= '0;
    else if ((state == WAIT_RISE) && rise_q)
      high_cnt <= 32'd1;
    else if ((state == HIGH) && s3 && (high_cnt != 32'hFFFF_FFFF))
      high_cnt <= high_cnt + 32'd1;
  end

  // Result register, handshake and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.pulse_length   <= MIN_PULSE_LENGTH;
      bus.new_data_ready <= 1'b0;
      range_err          <= 1'b0;
      overrun            <= 1'b0;
      signal_lost        <= 1'b1;
    end else begin
      range_err <= bad;
      overrun   <= 1'b0;
      if (good) begin
        // A fresh result beats a same-cycle acknowledge
        bus.pulse_length   <= high_cnt;
        bus.new_data_ready <= 1'b1;
        overrun            <= bus.new_data_ready && !bus.data_recieved;
        signal_lost        <= 1'b0;
      end else if (bus.data_recieved) begin
        bus.new_data_ready <= 1'b0;
      end
      if (timeout_hit)
        signal_lost <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_capture
//  Description : Directed self-checking bench for pwm_capture with reduced
//                width limits and timeout so the run stays short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

  localparam logic [31:0] MIN_L = 32'd20;
  localparam logic [31:0] MAX_L = 32'd40;
  localparam logic [31:0] TO    = 32'd300;
  localparam int          FD    = 4;
`ifdef PWM_GLITCH_FILTER_EN
  localparam int LAT = 4 + FD;
`else
  localparam int LAT = 4;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic pwm_in;
  logic range_err, overrun, signal_lost;

  pwm_capture_if bus ();

  pwm_capture #(
    .MIN_PULSE_LENGTH (MIN_L),
    .MAX_PULSE_LENGTH (MAX_L),
    .TIMEOUT          (TO),
    .FILTER_DEPTH     (FD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pwm_in      (pwm_in),
    .bus         (bus),
    .range_err   (range_err),
    .overrun     (overrun),
    .signal_lost (signal_lost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int re_cnt   = 0;
  int ov_cnt   = 0;
  int re0, ov0;

  // Count one-cycle status pulses away from the active edge
  always @(negedge clk) begin
    if (range_err === 1'b1) re_cnt++;
    if (overrun   === 1'b1) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // High for exactly n sampling edges, then low
  task automatic pulse_hi(input int n);
    pwm_in = 1'b1;
    repeat (n) tick();
    pwm_in = 1'b0;
  endtask

  task automatic send(input int n);
    pulse_hi(n);
    repeat (LAT + 2) tick();
  endtask

  task automatic ack();
    bus.data_recieved = 1'b1;
    tick();
    bus.data_recieved = 1'b0;
    check("ack_clears", {31'd0, bus.new_data_ready}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    bus.data_recieved = 1'b0;
    repeat (3) tick();
    check("rst_len",  bus.pulse_length, MIN_L);
    check("rst_ndr",  {31'd0, bus.new_data_ready}, 32'd0);
    check("rst_re",   {31'd0, range_err}, 32'd0);
    check("rst_ov",   {31'd0, overrun}, 32'd0);
    check("rst_lost", {31'd0, signal_lost}, 32'd1);
    reset_n = 1'b1;
    repeat (10) tick();

    // First valid pulse: latency and signal_lost release
    pulse_hi(30);
    repeat (LAT - 1) tick();
    check("lat_ndr_early", {31'd0, bus.new_data_ready}, 32'd0);
    check("lat_lost_early", {31'd0, signal_lost}, 32'd1);
    tick();
    check("lat_ndr", {31'd0, bus.new_data_ready}, 32'd1);
    check("lat_len", bus.pulse_length, 32'd30);
    check("lat_lost", {31'd0, signal_lost}, 32'd0);
    ack();

    // Inclusive bounds
    send(20);
    check("min_len", bus.pulse_length, 32'd20);
    check("min_ndr", {31'd0, bus.new_data_ready}, 32'd1);
    ack();
    send(40);
    check("max_len", bus.pulse_length, 32'd40);
    ack();

    // Just outside the bounds
    re0 = re_cnt;
    send(19);
    check("below_re", re_cnt, re0 + 1);
    check("below_len", bus.pulse_length, 32'd40);
    check("below_ndr", {31'd0, bus.new_data_ready}, 32'd0);
    send(41);
    check("above_re", re_cnt, re0 + 2);
    check("above_len", bus.pulse_length, 32'd40);
    check("above_ndr", {31'd0, bus.new_data_ready}, 32'd0);

    // Overrun: two results without acknowledge
    ov0 = ov_cnt;
    send(25);
    check("ovr_first_ov", ov_cnt, ov0);
    send(35);
    check("ovr_cnt", ov_cnt, ov0 + 1);
    check("ovr_len", bus.pulse_length, 32'd35);
    check("ovr_ndr", {31'd0, bus.new_data_ready}, 32'd1);
    ack();

    // Acknowledge in the same cycle a new result latches
    send(25);
    ov0 = ov_cnt;
    pulse_hi(35);
    repeat (LAT - 1) tick();
    bus.data_recieved = 1'b1;
    tick();
    bus.data_recieved = 1'b0;
    check("same_ndr", {31'd0, bus.new_data_ready}, 32'd1);
    check("same_len", bus.pulse_length, 32'd35);
    check("same_ov", ov_cnt, ov0);
    ack();

    // Loss of signal, invalid pulse does not clear it, valid one does
    repeat (310) tick();
    check("lost_set", {31'd0, signal_lost}, 32'd1);
    re0 = re_cnt;
    send(19);
    check("lost_bad_re", re_cnt, re0 + 1);
    check("lost_bad_keep", {31'd0, signal_lost}, 32'd1);
    pulse_hi(30);
    repeat (LAT - 1) tick();
    check("lost_hold", {31'd0, signal_lost}, 32'd1);
    tick();
    check("lost_clr", {31'd0, signal_lost}, 32'd0);
    check("lost_len", bus.pulse_length, 32'd30);
    ack();

    // Line stuck high: loss flagged, no result on the eventual fall
    re0 = re_cnt;
    pwm_in = 1'b1;
    repeat (350) tick();
    check("stuck_lost", {31'd0, signal_lost}, 32'd1);
    pwm_in = 1'b0;
    repeat (LAT + 3) tick();
    check("stuck_ndr", {31'd0, bus.new_data_ready}, 32'd0);
    check("stuck_re", re_cnt, re0);
    send(33);
    check("recover_len", bus.pulse_length, 32'd33);
    check("recover_lost", {31'd0, signal_lost}, 32'd0);
    ack();

    // Reset asserted and released while the line is high
    pwm_in = 1'b1;
    tick();
    reset_n = 1'b0;
    repeat (2) tick();
    check("midrst_len", bus.pulse_length, MIN_L);
    check("midrst_lost", {31'd0, signal_lost}, 32'd1);
    reset_n = 1'b1;
    re0 = re_cnt;
    repeat (15) tick();
    pwm_in = 1'b0;
    repeat (LAT + 5) tick();
    check("midrst_ndr", {31'd0, bus.new_data_ready}, 32'd0);
    check("midrst_re", re_cnt, re0);

    // Two-cycle low glitch inside a 30-cycle pulse
    re0 = re_cnt;
    pwm_in = 1'b1;
    repeat (15) tick();
    pwm_in = 1'b0;
    repeat (2) tick();
    pwm_in = 1'b1;
    repeat (13) tick();
    pwm_in = 1'b0;
    repeat (LAT + 3) tick();
`ifdef PWM_GLITCH_FILTER_EN
    check("glitch_len", bus.pulse_length, 32'd30);
    check("glitch_ndr", {31'd0, bus.new_data_ready}, 32'd1);
    check("glitch_re", re_cnt, re0);
`else
    check("glitch_re", re_cnt, re0 + 2);
    check("glitch_ndr", {31'd0, bus.new_data_ready}, 32'd0);
    check("glitch_len", bus.pulse_length, MIN_L);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the servo PWM generator: measures the high time of an incoming servo-style PWM pulse in clk cycles.
- Range-checks each pulse and presents valid widths on a level handshake using the same pulse_length / new_data_ready / data_recieved semantics as the generator's input side.
- Sits between an RC receiver or servo-line input pin and control logic; also flags loss of signal.

Parameters:
- MIN_PULSE_LENGTH, 32'hD0FC, shortest accepted high time in clk cycles (53,500).
- MAX_PULSE_LENGTH, 32'h17CDC, longest accepted high time in clk cycles (97,500).
- TIMEOUT, 32'h2191C0, cycles without a rising edge before signal_lost asserts (2,200,000 = 2 frames).
- FILTER_DEPTH, 4, glitch filter length in cycles; used only when PWM_GLITCH_FILTER_EN is defined.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- pwm_in  input  1  asynchronous PWM line
- data_recieved  input  1  consumer acknowledge; sampled high pops the current result
- pulse_length  output  32  last valid measured high time, in cycles
- new_data_ready  output  1  result valid, held until acknowledged
- range_err  output  1  one-cycle pulse: measured width outside [MIN, MAX]
- overrun  output  1  one-cycle pulse: unacknowledged result overwritten
- signal_lost  output  1  level: no rising edge within TIMEOUT

Behaviour:
- Reset (reset_n low, asynchronous):
  - pulse_length = MIN_PULSE_LENGTH; new_data_ready, range_err, overrun = 0; signal_lost = 1.
  - Synchronizer flops = 0; counters = 0; state = SYNC.
- Input path:
  - 2-flop synchronizer s1→s2; s3 holds the previous s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- FSM states:
  - SYNC: wait for s2 == 0, then go to WAIT_RISE. This discards any partial pulse present at reset or after signal loss.
  - WAIT_RISE: on rise, clear high_cnt to 1 and go to HIGH.
  - HIGH: high_cnt increments each cycle s2 == 1. On fall, evaluate high_cnt and go to WAIT_RISE.
- Counter rules:
  - high_cnt is 32-bit and saturates at 32'hFFFFFFFF; it never wraps.
  - A pwm_in held high synchronously for N clk cycles yields exactly high_cnt = N.
- Evaluation on fall:
  - If MIN_PULSE_LENGTH <= high_cnt <= MAX_PULSE_LENGTH (both bounds inclusive): pulse_length <= high_cnt and new_data_ready <= 1.
  - Otherwise: range_err pulses for 1 cycle; pulse_length and new_data_ready are unchanged.
- Latency: new_data_ready rises on the 4th rising clk edge after pwm_in falls (2 sync + 1 edge + 1 output register).
- Handshake:
  - new_data_ready stays high until a cycle in which data_recieved == 1; it clears on the following edge.
  - pulse_length stays stable while new_data_ready is high, except on overrun.
  - data_recieved high while new_data_ready is low: ignored.
- Simultaneous events:
  - Valid completion in the same cycle as an ack: the new result wins, so new_data_ready stays 1 and pulse_length is updated. No overrun.
  - Valid completion while new_data_ready == 1 and no ack: pulse_length is overwritten, new_data_ready stays 1, overrun pulses for 1 cycle.
- Timeout:
  - since_rise counts every cycle and clears on rise; it saturates.
  - When since_rise reaches TIMEOUT: signal_lost <= 1 and state <= SYNC; an in-progress measurement is discarded.
  - signal_lost clears on the same edge that sets new_data_ready for the next valid pulse. An invalid pulse does not clear it.
  - A line stuck high therefore produces signal_lost, never a result.
- Reset mid-pulse: all state is cleared, and the FSM waits for a low level before measuring again.

Optional Feature:
- Macro: PWM_GLITCH_FILTER_EN.
- Defined:
  - A debouncer is inserted after s2. The filtered level changes only after the raw synchronized level has differed from it for FILTER_DEPTH consecutive cycles.
  - Both edges are delayed by FILTER_DEPTH, so measured width is unchanged, and new_data_ready latency becomes 4+FILTER_DEPTH cycles.
  - High or low glitches shorter than FILTER_DEPTH cycles are invisible.
- Undefined: s2 feeds the edge detector directly, and a 1-cycle glitch during HIGH ends the measurement (typically producing range_err).

Test Plan:
- Reset, pwm_in low, then a 60,000-cycle high pulse → new_data_ready=1 four cycles after the fall; pulse_length=60000; signal_lost clears on the same edge.
- High pulses of 53,500 and 97,500 → both accepted. 53,499 and 97,501 → range_err pulse only; pulse_length holds its prior value; new_data_ready does not assert.
- Two valid pulses (60,000 then 70,000) with no ack → overrun pulses once; pulse_length=70000. Then ack asserted for 1 cycle → new_data_ready=0 on the next edge.
- Ack asserted in the exact cycle a 70,000 result latches → new_data_ready stays 1; overrun=0.
- pwm_in held low for 2,200,000 cycles after a valid pulse → signal_lost=1. Also: reset released while pwm_in high, then a fall → no result and no range_err.
- With PWM_GLITCH_FILTER_EN: a 2-cycle low glitch inside a 60,000-cycle pulse → pulse_length=60000. Without the macro → range_err.
